trigger_generator: RTL and testbench

TRIGGER_GENERATOR -- requirements
Module: trigger_generator

---
 rtl/trigger_pkg.sv | 19 +
 rtl/trigger_pulse_timer.sv | 31 +++
 rtl/trigger_generator.sv | 174 +++++++++++++++++
 tb/tb_trigger_generator.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_pkg.sv
// trigger_pkg: state encoding and default widths shared by
// the trigger generator and the trigger receiver.
package trigger_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } trig_state_t;

  localparam int TRIG_WIDTH_BITS = 10;
  localparam int TRIG_GAP_BITS   = 16;
  localparam int TRIG_NUM_BITS   = 16;

  function automatic int max_bits(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/trigger_pulse_timer.sv
// trigger_pulse_timer: loadable down-counter timing one
// pulse or gap phase; expire marks the phase's last cycle.
module trigger_pulse_timer #(
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                clear,
  input  logic                count_en,
  input  logic [CNT_BITS-1:0] load_val,
  output logic [CNT_BITS-1:0] cnt,
  output logic                expire
);

  // remaining cycles of the current phase, current included
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_en && cnt != '0) begin
      cnt <= cnt - CNT_BITS'(1);
    end
  end

  assign expire = (cnt == CNT_BITS'(1));

endmodule

// File: rtl/trigger_generator.sv
// trigger_generator: burst pulse generator with differential
// output. Define TRIGGER_GENERATOR_ILA_EN to add a debug core.
module trigger_generator
  import trigger_pkg::*;
#(
  parameter int WIDTH_BITS = TRIG_WIDTH_BITS,
  parameter int GAP_BITS   = TRIG_GAP_BITS,
  parameter int NUM_BITS   = TRIG_NUM_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_trigger,
  input  logic                  start,
  input  logic                  stop,
  input  logic [WIDTH_BITS-1:0] trigger_width,
  input  logic [GAP_BITS-1:0]   trigger_gap,
  input  logic [NUM_BITS-1:0]   trigger_number,
  output logic                  trigger_out_p,
  output logic                  trigger_out_n,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_BITS-1:0]   sent_count
);

  localparam int CNT_BITS = max_bits(WIDTH_BITS, GAP_BITS);

  trig_state_t state_q;
  trig_state_t state_d;

  logic [WIDTH_BITS-1:0] width_q;
  logic [GAP_BITS-1:0]   gap_q;
  logic [NUM_BITS-1:0]   num_q;
  logic [NUM_BITS-1:0]   sent_q;
  logic                  abort_q;

  logic                  accept;
  logic                  abort_now;
  logic                  done_d;
  logic                  tmr_load;
  logic                  tmr_clear;
  logic [CNT_BITS-1:0]   tmr_val;
  logic [CNT_BITS-1:0]   cnt;
  logic                  expire;
  logic [CNT_BITS-1:0]   w_new;
  logic [CNT_BITS-1:0]   w_lat;
  logic [CNT_BITS-1:0]   g_lat;
  logic                  trigger;

  assign accept    = (state_q == IDLE) && enable_trigger
                     && start && !stop;
  assign abort_now = stop || !enable_trigger;

  // zero-length phases run for one cycle
  assign w_new = (trigger_width == '0) ? CNT_BITS'(1)
                                       : CNT_BITS'(trigger_width);
  assign w_lat = (width_q == '0) ? CNT_BITS'(1)
                                 : CNT_BITS'(width_q);
  assign g_lat = (gap_q == '0) ? CNT_BITS'(1)
                               : CNT_BITS'(gap_q);

  trigger_pulse_timer #(
    .CNT_BITS (CNT_BITS)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .clear    (tmr_clear),
    .count_en (state_q != IDLE),
    .load_val (tmr_val),
    .cnt      (cnt),
    .expire   (expire)
  );

  // next state, timer control and end-of-burst strobe
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;
    tmr_val   = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = PULSE;
          tmr_load = 1'b1;
          tmr_val  = w_new;
        end
      end
      PULSE: begin
        if (expire) begin
          if (abort_q || abort_now) begin
            state_d   = IDLE;
            done_d    = 1'b1;
            tmr_clear = 1'b1;
          end else begin
            state_d  = GAP;
            tmr_load = 1'b1;
            tmr_val  = g_lat;
          end
        end
      end
      GAP: begin
        if (abort_now) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          tmr_clear = 1'b1;
        end else if (expire) begin
          if (num_q != '0 && sent_q == num_q) begin
            state_d   = IDLE;
            done_d    = 1'b1;
            tmr_clear = 1'b1;
          end else begin
            state_d  = PULSE;
            tmr_load = 1'b1;
            tmr_val  = w_lat;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        tmr_clear = 1'b1;
      end
    endcase
  end

  // state, latched burst settings, pulse count, pending abort
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      width_q <= '0;
      gap_q   <= '0;
      num_q   <= '0;
      sent_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        width_q <= trigger_width;
        gap_q   <= trigger_gap;
        num_q   <= trigger_number;
        sent_q  <= '0;
      end else if (state_q == PULSE && expire
                   && sent_q != '1) begin
        sent_q <= sent_q + NUM_BITS'(1);
      end
      if (state_d == IDLE) begin
        abort_q <= 1'b0;
      end else if (state_q == PULSE && abort_now) begin
        abort_q <= 1'b1;
      end
    end
  end

  assign trigger       = (state_q == PULSE);
  assign trigger_out_p = trigger;
  assign trigger_out_n = ~trigger;
  assign busy          = (state_q != IDLE);
  assign done          = done_d & rst_n;
  assign sent_count    = sent_q;

`ifdef TRIGGER_GENERATOR_ILA_EN
  trigger_generator_ila u_ila (
    .clk    (clk),
    .probe0 (state_q),
    .probe1 (cnt),
    .probe2 (sent_q),
    .probe3 (trigger)
  );
`else
  logic unused_dbg;
  assign unused_dbg = ^cnt;
`endif

endmodule

// File: tb/tb_trigger_generator.sv
// tb_trigger_generator: directed scenarios plus random traffic
// checked each cycle against a timeline model of the burst.
module tb_trigger_generator;

  logic        clk;
  logic        rst_n;
  logic        enable_trigger;
  logic        start;
  logic        stop;
  logic [9:0]  trigger_width;
  logic [15:0] trigger_gap;
  logic [15:0] trigger_number;
  logic        trigger_out_p;
  logic        trigger_out_n;
  logic        busy;
  logic        done;
  logic [15:0] sent_count;

  trigger_generator dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable_trigger (enable_trigger),
    .start          (start),
    .stop           (stop),
    .trigger_width  (trigger_width),
    .trigger_gap    (trigger_gap),
    .trigger_number (trigger_number),
    .trigger_out_p  (trigger_out_p),
    .trigger_out_n  (trigger_out_n),
    .busy           (busy),
    .done           (done),
    .sent_count     (sent_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int BIG = 32'h7fff_ffff;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  bit mdl_ok = 0;
  bit active = 0;
  int t0, mw, mg, mn, per, end_c;
  int last_sent = 0;
  int hi_cnt, done_cnt;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               tag, cyc, obs, exp);
    end
  endtask

  // pulses whose last high cycle lies before cycle c
  function automatic int sent_at(int c);
    if (c > t0 + mw) return (c - 1 - t0 - mw) / per + 1;
    return 0;
  endfunction

  task automatic check_cycle();
    int rel, k, e;
    bit inp;
    bit et, eb, ed;
    int es;
    if (active) begin
      rel = cyc - t0 - 1;
      k   = rel / per;
      inp = (rel % per) < mw;
      if (rst_n && (stop || !enable_trigger)) begin
        e = inp ? t0 + k * per + mw : cyc;
        if (e < end_c) end_c = e;
      end
      et = inp;
      eb = 1'b1;
      ed = rst_n && (cyc == end_c);
      es = sent_at(cyc);
    end else begin
      et = 1'b0;
      eb = 1'b0;
      ed = 1'b0;
      es = last_sent;
    end
    if (mdl_ok) begin
      chk("trig_p", 32'(trigger_out_p), 32'(et));
      chk("trig_n", 32'(trigger_out_n), 32'(!et));
      chk("busy", 32'(busy), 32'(eb));
      chk("done", 32'(done), 32'(ed));
      chk("sent", 32'(sent_count), es);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      active    = 0;
      last_sent = 0;
      mdl_ok    = 1;
    end else if (active) begin
      if (cyc == end_c) begin
        active    = 0;
        last_sent = sent_at(cyc + 1);
      end
    end else if (start && enable_trigger && !stop) begin
      active = 1;
      t0     = cyc;
      mw     = (trigger_width == 0) ? 1 : int'(trigger_width);
      mg     = (trigger_gap == 0) ? 1 : int'(trigger_gap);
      mn     = int'(trigger_number);
      per    = mw + mg;
      end_c  = (mn != 0) ? t0 + mn * per : BIG;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    if (trigger_out_p === 1'b1) hi_cnt++;
    if (done === 1'b1) done_cnt++;
    model_edge();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_cfg(int w, int g, int n);
    trigger_width  = 10'(w);
    trigger_gap    = 16'(g);
    trigger_number = 16'(n);
  endtask

  initial begin
    rst_n          = 1'b0;
    enable_trigger = 1'b1;
    start          = 1'b0;
    stop           = 1'b0;
    set_cfg(0, 0, 0);
    ticks(2);
    rst_n = 1'b1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sent", 32'(sent_count), 0);
    chk("rst_trig", 32'(trigger_out_p), 0);
    ticks(2);

    // width 3, gap 2, two pulses
    set_cfg(3, 2, 2);
    hi_cnt = 0; done_cnt = 0;
    pulse_start();
    set_cfg(7, 7, 7);
    ticks(12);
    chk("b1_hi", hi_cnt, 6);
    chk("b1_done", done_cnt, 1);
    chk("b1_sent", 32'(sent_count), 2);
    chk("b1_busy", 32'(busy), 0);

    // zero width and gap behave as one cycle
    set_cfg(0, 0, 1);
    hi_cnt = 0; done_cnt = 0;
    pulse_start();
    ticks(5);
    chk("b2_hi", hi_cnt, 1);
    chk("b2_done", done_cnt, 1);
    chk("b2_sent", 32'(sent_count), 1);

    // continuous, stop in 2nd cycle of 3rd pulse
    set_cfg(4, 4, 0);
    hi_cnt = 0; done_cnt = 0;
    pulse_start();
    ticks(17);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    ticks(6);
    chk("b3_hi", hi_cnt, 12);
    chk("b3_done", done_cnt, 1);
    chk("b3_sent", 32'(sent_count), 3);

    // start ignored when disabled
    enable_trigger = 1'b0;
    set_cfg(2, 3, 3);
    hi_cnt = 0; done_cnt = 0;
    pulse_start();
    ticks(4);
    enable_trigger = 1'b1;
    chk("dis_hi", hi_cnt, 0);
    chk("dis_busy", 32'(busy), 0);

    // restart and new settings while busy are ignored
    pulse_start();
    set_cfg(9, 1, 1);
    ticks(3);
    pulse_start();
    ticks(12);
    chk("bz_hi", hi_cnt, 6);
    chk("bz_sent", 32'(sent_count), 3);

    // reset cuts a pulse, no done
    set_cfg(5, 1, 0);
    hi_cnt = 0; done_cnt = 0;
    pulse_start();
    tick();
    rst_n = 1'b0;
    tick();
    chk("r_trig_p", 32'(trigger_out_p), 0);
    chk("r_trig_n", 32'(trigger_out_n), 1);
    chk("r_sent", 32'(sent_count), 0);
    rst_n = 1'b1;
    ticks(3);
    chk("r_done", done_cnt, 0);

    // start with stop in same cycle stays idle
    set_cfg(2, 2, 1);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_busy", 32'(busy), 0);
    ticks(2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      start          = ($urandom_range(5) == 0);
      stop           = ($urandom_range(39) == 0);
      enable_trigger = ($urandom_range(29) != 0);
      rst_n          = ($urandom_range(499) != 0);
      set_cfg($urandom_range(5), $urandom_range(5),
              $urandom_range(3));
      tick();
    end
    rst_n = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    ticks(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
